// File: rtl/fir_out_decimator.sv
// Post-FIR output stage: rounds and saturates each kept sample, decimates by DECIM,
// and buffers results in a small FIFO presented as a valid/ready stream.
module fir_out_decimator #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SHIFT = 2,
  parameter int unsigned DECIM = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IN_W-1:0]          y_in,
  input  logic                     y_valid,
  output logic [OUT_W-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     saturated
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned PhW  = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [IN_W:0] Round  = (SHIFT == 0) ? '0 : ((IN_W+1)'(1) << (SHIFT - 1));
  localparam logic [IN_W:0] OutMax = {{(IN_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic [PhW-1:0]  PhLast = PhW'(DECIM - 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

  // Decimation phase
  logic [PhW-1:0] phase_q;
  logic           keep;

  // Stage 1: scaled sample
  logic [IN_W:0]      rounded;
  logic [IN_W:0]      scaled;
  logic               clip;
  logic [OUT_W-1:0]   s1_data_d;
  logic [OUT_W-1:0]   s1_data_q;
  logic               s1_valid_q;

  // FIFO
  logic [OUT_W-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             pop;
  logic             push;
  logic             drop;
  logic             full;
  logic             overflow_q;
  logic             saturated_q;

  assign keep = y_valid && (phase_q == '0);

  // Scaling is done one bit wider than the input so the rounding add cannot wrap.
  always_comb begin
    rounded   = {1'b0, y_in} + Round;
    scaled    = rounded >> SHIFT;
    clip      = (scaled > OutMax);
    s1_data_d = clip ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
    end else if (y_valid) begin
      phase_q <= (phase_q == PhLast) ? '0 : phase_q + PhW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= keep;
      if (keep) begin
        s1_data_q <= s1_data_d;
      end
    end
  end

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  always_comb begin
    full    = (level_q == LvlFull);
    m_valid = (level_q != '0);
    pop     = m_valid && m_ready;
    push    = s1_valid_q && (!full || pop);
    drop    = s1_valid_q && full && !pop;
    m_data  = m_valid ? mem[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr_q] <= s1_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (keep && clip) begin
        saturated_q <= 1'b1;
      end
    end
  end

  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign saturated  = saturated_q;

endmodule
